write_back_stage: RTL and testbench
===================================

Name: write_back_stage

Overview:
Pipeline stage between execute/memory and the register file. It captures one execute result per transaction, optionally waits for memory load data, and decodes the destination channels. For exactly one cycle it presents the per-register data and change flags (back_*, back_*_c). The register file commits from those signals, and the data bypass forwards them to operand fetch in the same cycle.

Parameters:
DW, 32, data width of all register values
CW, 4, destination channel code width

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
in_valid  input  1  execute result valid
in_ready  output  1  stage can accept a result this cycle
y1_channel  input  4  primary destination channel
y1_data  input  32  primary result; ignored when mem_load=1
y2_channel  input  2  secondary destination: 0 none, 1 flag, 2 sp
y2_data  input  32  secondary result
mem_load  input  1  primary data comes from the memory response
sys_info  input  32  CPU config; bit 2 set = TLB write locked
mem_rsp_valid  input  1  memory load data valid
mem_rsp_data  input  32  memory load data
flush  input  1  discard pending/accepted result
load_wait  output  1  stage is waiting on memory
back_r1..back_r7, back_ds, back_flag, back_tpc, back_ipc, back_sp, back_tlb  output  32 each  write-back data
back_r1_c..back_r7_c, back_ds_c, back_flag_c, back_tpc_c, back_ipc_c, back_sp_c, back_tlb_c  output  1 each  write-back change flags

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Channel codes: 1-7 r1-r7, 8 ds, 9 flag, 10 pc, 11 tpc, 12 ipc, 13 sp, 14 tlb, 15 sys.
- Channels 0, 10 and 15 produce no write. Channel 14 produces no write if sys_info[2] was set at acceptance.
- States: IDLE, WAIT_MEM, COMMIT.
- in_ready = (state != WAIT_MEM). Acceptance = in_valid && in_ready.
- IDLE, on accept:
  - mem_load=0: latch y1/y2 and the tlb-lock bit, go to COMMIT.
  - mem_load=1: latch channels, go to WAIT_MEM.
- WAIT_MEM: load_wait=1.
  - On mem_rsp_valid: latch mem_rsp_data as the y1 value, go to COMMIT. Commit is 1 cycle after the response.
  - mem_rsp_valid while not in WAIT_MEM is ignored.
- COMMIT, for one cycle:
  - Assert the _c flag of each decoded destination.
  - Next state: a new accept in the same cycle behaves as from IDLE; otherwise go to IDLE. This gives back-to-back throughput of 1 per cycle.
- Latency: non-load result appears on back_* the cycle after acceptance.
- Change flags are registered and high only in COMMIT. At most two are high (y1 and y2).
- back_* data registers update only for written destinations. They hold their last value otherwise.
- Collision: if y1 and y2 target the same register (y1=9 with y2=1, or y1=13 with y2=2), y2_data wins and a single _c is asserted.
- flush: highest priority.
  - Next state is IDLE, all _c deasserted next cycle, no acceptance that cycle.
  - A WAIT_MEM transaction is dropped, and its later memory response is ignored.
  - back_* data is unchanged.
- Reset: state IDLE; all back_* = 0; all _c = 0; load_wait = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-WAIT_MEM abandons the transaction; no commit occurs.

Decomposition:
- Shared package: channel code constants (CH_NONE=0 ... CH_SYS=15), y2 code constants, and the SYSINFO_TLB_LOCK bit index (2). The data bypass uses the same package.
- One natural sub-module: wb_channel_decoder. It is combinational: channel codes plus the lock bit map to a 13-bit write-enable vector. It is reusable by the bypass.

Test Plan:
- Reset, then in_valid with y1_channel=3, y1_data=0x1234, mem_load=0 -> next cycle back_r3=0x1234 and back_r3_c=1 for one cycle; all other _c=0.
- Load: y1_channel=8 with mem_load=1; mem_rsp_valid 3 cycles later with data 0xCAFEBABE -> in_ready=0 and load_wait=1 during wait; back_ds=0xCAFEBABE and back_ds_c=1 one cycle after the response.
- Collision: y1_channel=9, y1_data=5, y2_channel=1, y2_data=7 -> back_flag=7; only back_flag_c asserted.
- TLB lock: sys_info[2]=1 with y1_channel=14 -> no _c asserted and back_tlb unchanged; the same with sys_info[2]=0 -> back_tlb_c=1.
- Back-to-back: results to r1, r2, r3 on consecutive cycles with in_valid held -> back_r1_c, back_r2_c, back_r3_c each high on successive cycles; in_ready stays 1.
- Flush during WAIT_MEM, then a late mem_rsp_valid -> no commit, state IDLE, in_ready=1 the cycle after the flush.

Source files
------------

// File: rtl/write_back_stage_pkg.sv
// Shared definitions for the write-back stage and the operand bypass:
// channel codes, secondary-destination codes and write-enable bit positions.
package write_back_stage_pkg;

   localparam logic [3:0] CH_NONE = 4'd0;
   localparam logic [3:0] CH_R1   = 4'd1;
   localparam logic [3:0] CH_R2   = 4'd2;
   localparam logic [3:0] CH_R3   = 4'd3;
   localparam logic [3:0] CH_R4   = 4'd4;
   localparam logic [3:0] CH_R5   = 4'd5;
   localparam logic [3:0] CH_R6   = 4'd6;
   localparam logic [3:0] CH_R7   = 4'd7;
   localparam logic [3:0] CH_DS   = 4'd8;
   localparam logic [3:0] CH_FLAG = 4'd9;
   localparam logic [3:0] CH_PC   = 4'd10;
   localparam logic [3:0] CH_TPC  = 4'd11;
   localparam logic [3:0] CH_IPC  = 4'd12;
   localparam logic [3:0] CH_SP   = 4'd13;
   localparam logic [3:0] CH_TLB  = 4'd14;
   localparam logic [3:0] CH_SYS  = 4'd15;

   localparam logic [1:0] Y2_NONE = 2'd0;
   localparam logic [1:0] Y2_FLAG = 2'd1;
   localparam logic [1:0] Y2_SP   = 2'd2;

   localparam int SYSINFO_TLB_LOCK = 2;

   // Bit positions in the write-enable / change vectors.
   localparam int WB_N    = 13;
   localparam int WB_R1   = 0;
   localparam int WB_R2   = 1;
   localparam int WB_R3   = 2;
   localparam int WB_R4   = 3;
   localparam int WB_R5   = 4;
   localparam int WB_R6   = 5;
   localparam int WB_R7   = 6;
   localparam int WB_DS   = 7;
   localparam int WB_FLAG = 8;
   localparam int WB_TPC  = 9;
   localparam int WB_IPC  = 10;
   localparam int WB_SP   = 11;
   localparam int WB_TLB  = 12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_MEM,
      ST_COMMIT
   } wb_state_e;

endpackage

// File: rtl/wb_channel_decoder.sv
// Maps primary/secondary destination codes to per-register write enables.
// Purely combinational so the operand bypass can share it.
module wb_channel_decoder
   import write_back_stage_pkg::*;
#(
   parameter int CW = 4
) (
   input  logic [CW-1:0]   y1_channel_i,
   input  logic [1:0]      y2_channel_i,
   input  logic            tlb_lock_i,
   output logic [WB_N-1:0] y1_we_o,
   output logic [WB_N-1:0] y2_we_o
);

   always_comb begin
      y1_we_o = '0;
      case (y1_channel_i)
         CH_R1:   y1_we_o[WB_R1]   = 1'b1;
         CH_R2:   y1_we_o[WB_R2]   = 1'b1;
         CH_R3:   y1_we_o[WB_R3]   = 1'b1;
         CH_R4:   y1_we_o[WB_R4]   = 1'b1;
         CH_R5:   y1_we_o[WB_R5]   = 1'b1;
         CH_R6:   y1_we_o[WB_R6]   = 1'b1;
         CH_R7:   y1_we_o[WB_R7]   = 1'b1;
         CH_DS:   y1_we_o[WB_DS]   = 1'b1;
         CH_FLAG: y1_we_o[WB_FLAG] = 1'b1;
         CH_TPC:  y1_we_o[WB_TPC]  = 1'b1;
         CH_IPC:  y1_we_o[WB_IPC]  = 1'b1;
         CH_SP:   y1_we_o[WB_SP]   = 1'b1;
         CH_TLB:  y1_we_o[WB_TLB]  = !tlb_lock_i;
         default: y1_we_o = '0;  // none, pc and sys never write here
      endcase
   end

   always_comb begin
      y2_we_o = '0;
      case (y2_channel_i)
         Y2_FLAG: y2_we_o[WB_FLAG] = 1'b1;
         Y2_SP:   y2_we_o[WB_SP]   = 1'b1;
         default: y2_we_o = '0;
      endcase
   end

endmodule

// File: rtl/write_back_stage.sv
// Write-back stage: captures one execute result, optionally waits for load
// data, then presents per-register data and one-cycle change flags.
module write_back_stage
   import write_back_stage_pkg::*;
#(
   parameter int DW = 32,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] y1_channel,
   input  logic [DW-1:0] y1_data,
   input  logic [1:0]    y2_channel,
   input  logic [DW-1:0] y2_data,
   input  logic          mem_load,
   input  logic [31:0]   sys_info,
   input  logic          mem_rsp_valid,
   input  logic [DW-1:0] mem_rsp_data,
   input  logic          flush,
   output logic          load_wait,
   output logic [DW-1:0] back_r1, back_r2, back_r3, back_r4, back_r5, back_r6, back_r7,
   output logic [DW-1:0] back_ds, back_flag, back_tpc, back_ipc, back_sp, back_tlb,
   output logic          back_r1_c, back_r2_c, back_r3_c, back_r4_c, back_r5_c, back_r6_c,
   output logic          back_r7_c, back_ds_c, back_flag_c, back_tpc_c, back_ipc_c,
   output logic          back_sp_c, back_tlb_c
);

   wb_state_e       state_q, state_d;
   logic [CW-1:0]   y1ch_q, y1ch_d;
   logic [1:0]      y2ch_q, y2ch_d;
   logic [DW-1:0]   y2d_q, y2d_d;
   logic            lock_q, lock_d;
   logic [DW-1:0]   back_q [WB_N];
   logic [WB_N-1:0] chg_q, chg_d;

   logic            in_wait, accept, mem_done, commit;
   logic [CW-1:0]   sel_y1ch;
   logic [1:0]      sel_y2ch;
   logic [DW-1:0]   sel_y1d, sel_y2d;
   logic            sel_lock;
   logic [WB_N-1:0] we_y1, we_y2;
   logic            unused_sysinfo;

   assign unused_sysinfo = ^{sys_info[31:SYSINFO_TLB_LOCK+1], sys_info[SYSINFO_TLB_LOCK-1:0]};

   assign in_wait   = (state_q == ST_WAIT_MEM);
   assign in_ready  = !in_wait;
   assign load_wait = in_wait;
   assign accept    = in_valid && in_ready && !flush;
   assign mem_done  = in_wait && mem_rsp_valid && !flush;
   assign commit    = mem_done || (accept && !mem_load);

   // While waiting, the held destination meets the memory data; otherwise
   // the live execute result commits straight through.
   assign sel_y1ch = in_wait ? y1ch_q       : y1_channel;
   assign sel_y2ch = in_wait ? y2ch_q       : y2_channel;
   assign sel_y1d  = in_wait ? mem_rsp_data : y1_data;
   assign sel_y2d  = in_wait ? y2d_q        : y2_data;
   assign sel_lock = in_wait ? lock_q       : sys_info[SYSINFO_TLB_LOCK];

   wb_channel_decoder #(.CW(CW)) u_dec (
      .y1_channel_i (sel_y1ch),
      .y2_channel_i (sel_y2ch),
      .tlb_lock_i   (sel_lock),
      .y1_we_o      (we_y1),
      .y2_we_o      (we_y2)
   );

   assign chg_d = commit ? (we_y1 | we_y2) : '0;

   always_comb begin
      state_d = state_q;
      y1ch_d  = y1ch_q;
      y2ch_d  = y2ch_q;
      y2d_d   = y2d_q;
      lock_d  = lock_q;
      if (accept) begin
         y1ch_d = y1_channel;
         y2ch_d = y2_channel;
         y2d_d  = y2_data;
         lock_d = sys_info[SYSINFO_TLB_LOCK];
      end
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_COMMIT: begin
               if (accept) state_d = mem_load ? ST_WAIT_MEM : ST_COMMIT;
               else        state_d = ST_IDLE;
            end
            ST_WAIT_MEM: if (mem_rsp_valid) state_d = ST_COMMIT;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   // Control and architectural outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         chg_q   <= '0;
         for (int i = 0; i < WB_N; i++) back_q[i] <= '0;
      end else begin
         state_q <= state_d;
         chg_q   <= chg_d;
         for (int i = 0; i < WB_N; i++) begin
            // Secondary result wins when both target the same register.
            if (chg_d[i]) back_q[i] <= we_y2[i] ? sel_y2d : sel_y1d;
         end
      end
   end

   // Held transaction fields
   always_ff @(posedge clk) begin
      y1ch_q <= y1ch_d;
      y2ch_q <= y2ch_d;
      y2d_q  <= y2d_d;
      lock_q <= lock_d;
   end

   assign back_r1   = back_q[WB_R1];
   assign back_r2   = back_q[WB_R2];
   assign back_r3   = back_q[WB_R3];
   assign back_r4   = back_q[WB_R4];
   assign back_r5   = back_q[WB_R5];
   assign back_r6   = back_q[WB_R6];
   assign back_r7   = back_q[WB_R7];
   assign back_ds   = back_q[WB_DS];
   assign back_flag = back_q[WB_FLAG];
   assign back_tpc  = back_q[WB_TPC];
   assign back_ipc  = back_q[WB_IPC];
   assign back_sp   = back_q[WB_SP];
   assign back_tlb  = back_q[WB_TLB];

   assign back_r1_c   = chg_q[WB_R1];
   assign back_r2_c   = chg_q[WB_R2];
   assign back_r3_c   = chg_q[WB_R3];
   assign back_r4_c   = chg_q[WB_R4];
   assign back_r5_c   = chg_q[WB_R5];
   assign back_r6_c   = chg_q[WB_R6];
   assign back_r7_c   = chg_q[WB_R7];
   assign back_ds_c   = chg_q[WB_DS];
   assign back_flag_c = chg_q[WB_FLAG];
   assign back_tpc_c  = chg_q[WB_TPC];
   assign back_ipc_c  = chg_q[WB_IPC];
   assign back_sp_c   = chg_q[WB_SP];
   assign back_tlb_c  = chg_q[WB_TLB];

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: directed vectors, a transaction-level model
// compared every cycle, and literal expectations at key points.
module tb_write_back_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, mem_load, mem_rsp_valid, flush;
   logic [3:0]  y1_channel;
   logic [1:0]  y2_channel;
   logic [31:0] y1_data, y2_data, sys_info, mem_rsp_data;
   logic        in_ready, load_wait;
   logic [31:0] back_r1, back_r2, back_r3, back_r4, back_r5, back_r6, back_r7;
   logic [31:0] back_ds, back_flag, back_tpc, back_ipc, back_sp, back_tlb;
   logic        back_r1_c, back_r2_c, back_r3_c, back_r4_c, back_r5_c, back_r6_c, back_r7_c;
   logic        back_ds_c, back_flag_c, back_tpc_c, back_ipc_c, back_sp_c, back_tlb_c;

   write_back_stage #(.DW(32), .CW(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .y1_channel(y1_channel), .y1_data(y1_data), .y2_channel(y2_channel), .y2_data(y2_data),
      .mem_load(mem_load), .sys_info(sys_info), .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data), .flush(flush), .load_wait(load_wait),
      .back_r1(back_r1), .back_r2(back_r2), .back_r3(back_r3), .back_r4(back_r4),
      .back_r5(back_r5), .back_r6(back_r6), .back_r7(back_r7), .back_ds(back_ds),
      .back_flag(back_flag), .back_tpc(back_tpc), .back_ipc(back_ipc), .back_sp(back_sp),
      .back_tlb(back_tlb),
      .back_r1_c(back_r1_c), .back_r2_c(back_r2_c), .back_r3_c(back_r3_c), .back_r4_c(back_r4_c),
      .back_r5_c(back_r5_c), .back_r6_c(back_r6_c), .back_r7_c(back_r7_c), .back_ds_c(back_ds_c),
      .back_flag_c(back_flag_c), .back_tpc_c(back_tpc_c), .back_ipc_c(back_ipc_c),
      .back_sp_c(back_sp_c), .back_tlb_c(back_tlb_c)
   );

   always #5 clk = ~clk;

   // Register order: r1..r7, ds, flag, tpc, ipc, sp, tlb
   logic [31:0] dut_d [13];
   logic [12:0] dut_c;
   always_comb begin
      dut_d[0] = back_r1;  dut_d[1] = back_r2;   dut_d[2]  = back_r3;  dut_d[3]  = back_r4;
      dut_d[4] = back_r5;  dut_d[5] = back_r6;   dut_d[6]  = back_r7;  dut_d[7]  = back_ds;
      dut_d[8] = back_flag; dut_d[9] = back_tpc; dut_d[10] = back_ipc; dut_d[11] = back_sp;
      dut_d[12] = back_tlb;
   end
   assign dut_c = {back_tlb_c, back_sp_c, back_ipc_c, back_tpc_c, back_flag_c, back_ds_c,
                   back_r7_c, back_r6_c, back_r5_c, back_r4_c, back_r3_c, back_r2_c, back_r1_c};

   string names [13] = '{"r1", "r2", "r3", "r4", "r5", "r6", "r7",
                         "ds", "flag", "tpc", "ipc", "sp", "tlb"};
   // Channel code -> register slot; -1 means the code writes nothing here.
   int chmap [16] = '{-1, 0, 1, 2, 3, 4, 5, 6, 7, 8, -1, 9, 10, 11, 12, -1};

   // ---------------- transaction-level model ----------------
   logic [31:0] m_regs [13];
   logic [12:0] m_c;
   bit          m_wait, m_ok;
   logic [3:0]  p_y1ch;
   logic [1:0]  p_y2ch;
   logic [31:0] p_y2d;
   bit          p_lock;

   task automatic m_apply(input logic [3:0] c1, input logic [31:0] d1,
                          input logic [1:0] c2, input logic [31:0] d2, input bit lock);
      int r1, r2;
      r1 = chmap[c1];
      if (c1 == 4'd14 && lock) r1 = -1;
      r2 = (c2 == 2'd1) ? 8 : (c2 == 2'd2) ? 11 : -1;
      if (r1 >= 0) begin m_regs[r1] = d1; m_c[r1] = 1'b1; end
      if (r2 >= 0) begin m_regs[r2] = d2; m_c[r2] = 1'b1; end
   endtask

   always @(posedge clk) begin
      m_ok = 1'b1;
      m_c  = '0;
      if (rst) begin
         m_wait = 1'b0;
         for (int i = 0; i < 13; i++) m_regs[i] = '0;
      end else if (flush) begin
         m_wait = 1'b0;
      end else if (m_wait) begin
         if (mem_rsp_valid) begin
            m_apply(p_y1ch, mem_rsp_data, p_y2ch, p_y2d, p_lock);
            m_wait = 1'b0;
         end
      end else if (in_valid) begin
         if (mem_load) begin
            p_y1ch = y1_channel; p_y2ch = y2_channel; p_y2d = y2_data;
            p_lock = sys_info[2];
            m_wait = 1'b1;
         end else begin
            m_apply(y1_channel, y1_data, y2_channel, y2_data, sys_info[2]);
         end
      end
   end

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      for (int i = 0; i < 13; i++) chk({"model_back_", names[i]}, dut_d[i], m_regs[i]);
      chk("model_change", 32'(dut_c), 32'(m_c));
      chk("model_in_ready", 32'(in_ready), 32'(!m_wait));
      chk("model_load_wait", 32'(load_wait), 32'(m_wait));
   endtask

   task automatic tick();
      @(negedge clk);
      if (m_ok) cmp_model();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      in_valid = 1'b0; mem_load = 1'b0; mem_rsp_valid = 1'b0; flush = 1'b0;
      y1_channel = 4'd0; y2_channel = 2'd0; sys_info = 32'd0;
   endtask

   task automatic send(input logic [3:0] c1, input logic [31:0] d1,
                       input logic [1:0] c2, input logic [31:0] d2, input bit ld);
      in_valid = 1'b1; y1_channel = c1; y1_data = d1; y2_channel = c2; y2_data = d2;
      mem_load = ld;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      m_ok = 1'b0;
      y1_data = '0; y2_data = '0; mem_rsp_data = '0;
      idle_in();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("reset_change", 32'(dut_c), 32'h0);
      chk("reset_back_r3", back_r3, 32'h0);
      chk("reset_in_ready", 32'(in_ready), 32'h1);
      chk("reset_load_wait", 32'(load_wait), 32'h0);

      // Simple r3 write
      send(4'd3, 32'h1234, 2'd0, 32'h0, 1'b0);
      tick(); idle_in();
      chk("r3_data", back_r3, 32'h1234);
      chk("r3_change", 32'(dut_c), 32'h0004);
      tick();
      chk("r3_change_drops", 32'(dut_c), 32'h0);
      chk("r3_data_holds", back_r3, 32'h1234);

      // Load into ds, response three cycles later
      send(4'd8, 32'hDEAD0000, 2'd0, 32'h0, 1'b1);
      tick(); idle_in();
      chk("load_in_ready", 32'(in_ready), 32'h0);
      chk("load_wait_high", 32'(load_wait), 32'h1);
      tick(); tick();
      chk("load_still_waiting", 32'(load_wait), 32'h1);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEBABE;
      tick(); idle_in();
      chk("load_ds_data", back_ds, 32'hCAFEBABE);
      chk("load_ds_change", 32'(dut_c), 32'h0080);
      chk("load_ready_again", 32'(in_ready), 32'h1);

      // Flag collision: y2 wins, single change flag
      send(4'd9, 32'd5, 2'd1, 32'd7, 1'b0);
      tick(); idle_in();
      chk("collision_flag", back_flag, 32'd7);
      chk("collision_change", 32'(dut_c), 32'h0100);

      // pc channel writes nothing, y2 still writes sp
      send(4'd10, 32'h1, 2'd2, 32'h77, 1'b0);
      tick(); idle_in();
      chk("pc_sp_data", back_sp, 32'h77);
      chk("pc_sp_change", 32'(dut_c), 32'h0800);

      // TLB locked, then unlocked
      send(4'd14, 32'hAAAA, 2'd0, 32'h0, 1'b0); sys_info = 32'h4;
      tick(); idle_in();
      chk("tlb_locked_change", 32'(dut_c), 32'h0);
      chk("tlb_locked_data", back_tlb, 32'h0);
      send(4'd14, 32'hAAAA, 2'd0, 32'h0, 1'b0);
      tick(); idle_in();
      chk("tlb_open_change", 32'(dut_c), 32'h1000);
      chk("tlb_open_data", back_tlb, 32'hAAAA);

      // Back-to-back r1, r2, r3
      send(4'd1, 32'h11, 2'd0, 32'h0, 1'b0);
      tick();
      chk("b2b_r1_change", 32'(dut_c), 32'h0001);
      chk("b2b_ready1", 32'(in_ready), 32'h1);
      send(4'd2, 32'h22, 2'd0, 32'h0, 1'b0);
      tick();
      chk("b2b_r2_change", 32'(dut_c), 32'h0002);
      chk("b2b_ready2", 32'(in_ready), 32'h1);
      send(4'd3, 32'h33, 2'd0, 32'h0, 1'b0);
      tick(); idle_in();
      chk("b2b_r3_change", 32'(dut_c), 32'h0004);
      chk("b2b_r3_data", back_r3, 32'h33);
      tick();

      // Flush during wait, then a late response
      send(4'd5, 32'h0, 2'd0, 32'h0, 1'b1);
      tick(); idle_in();
      chk("flush_pre_wait", 32'(load_wait), 32'h1);
      flush = 1'b1;
      tick(); idle_in();
      chk("flush_ready", 32'(in_ready), 32'h1);
      chk("flush_load_wait", 32'(load_wait), 32'h0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555;
      tick(); idle_in();
      chk("flush_late_rsp_change", 32'(dut_c), 32'h0);
      chk("flush_late_rsp_r5", back_r5, 32'h0);

      // Reset during wait abandons the load
      send(4'd6, 32'h0, 2'd0, 32'h0, 1'b1);
      tick(); idle_in();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h6666;
      tick(); idle_in();
      chk("rst_wait_change", 32'(dut_c), 32'h0);
      chk("rst_wait_r6", back_r6, 32'h0);
      chk("rst_wait_r1_cleared", back_r1, 32'h0);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
